if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter AW, default 8, PC/instruction-address width in bits.
REQ-002 Parameter IW, default 16, instruction width in bits.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (>=2); replaces the single link register.
REQ-004 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 pc_sel  in  2  next-PC select: 00 sequential, 01 return (pop RAS), 10 branch to br_target, 11 hold.
REQ-008 br_target  in  AW  branch target, and flush target.
REQ-009 call  in  1  push pc_q+1 onto RAS this cycle.
REQ-010 flush  in  1  squash all in-flight and output instructions, redirect to br_target.
REQ-011 imem_addr  out  AW  instruction memory address; memory has 1-cycle synchronous read.
REQ-012 imem_rdata  in  IW  memory data for the address presented in the previous cycle.
REQ-013 instr_out  out  IW  fetched instruction.
REQ-014 pc_out  out  AW  address of instr_out.
REQ-015 instr_valid  out  1  instr_out/pc_out valid.
REQ-016 instr_ready  in  1  consumer accepts instr_out when valid and ready.
REQ-017 ras_overflow  out  1  one-cycle pulse, push onto full RAS.
REQ-018 ras_underflow  out  1  one-cycle pulse, pop from empty RAS.

Function
REQ-019 Two stages: F1 = pc_q (address issued), F2 = req_v/req_pc (data returning); output register = instr_out/pc_out/instr_valid.
REQ-020 advance = !instr_valid | instr_ready; pc_sel and call are sampled only when advance=1, ignored otherwise.
REQ-021 imem_addr = advance ? pc_q : req_pc, so a stalled F2 entry re-reads its own address.
REQ-022 On advance: output register <= {imem_rdata, req_pc, req_v}; req_pc <= pc_q; req_v <= 1 for pc_sel 00/11, 0 for 01/10 (wrong-path squash).
REQ-023 On advance, pc_q next: 00 -> pc_q+1; 01 -> RAS top (RESET_PC if empty); 10 -> br_target; 11 -> pc_q with req_v <= 0.
REQ-024 On !advance: pc_q, req_v, req_pc, output register, RAS all hold.
REQ-025 All PC arithmetic modulo 2^AW; pc_q = 2^AW-1 sequential wraps to 0.
REQ-026 Latency: address issued in cycle t appears with instr_valid=1 at cycle t+2 when unstalled; throughput one instruction per cycle.
REQ-027 flush has priority over everything, acts regardless of advance: instr_valid <= 0, req_v <= 0, pc_q <= br_target, RAS unchanged, call ignored.
REQ-028 Push (call on advance) stores pc_q+1; full RAS overwrites oldest entry (circular), count stays RAS_DEPTH, ras_overflow pulses.
REQ-029 Pop (pc_sel 01 on advance) on empty RAS: count stays 0, target RESET_PC, ras_underflow pulses.
REQ-030 Simultaneous pop and push: top entry replaced by pc_q+1, count unchanged, no overflow/underflow flag.

Reset
REQ-031 rst low asynchronously forces pc_q=RESET_PC, req_v=0, req_pc=0, instr_valid=0, instr_out=0, pc_out=0, RAS count=0, ras_overflow=0, ras_underflow=0.
REQ-032 Reset asserted mid-stall or mid-flush discards all in-flight instructions; first valid output is mem[RESET_PC] two cycles after rst deasserts.

Structure
REQ-033 Shared package if_pkg holds pc_sel encodings (PCSEL_SEQ, PCSEL_RET, PCSEL_BR, PCSEL_HOLD).
REQ-034 RAS is a sub-module return_stack (params AW, RAS_DEPTH; ports push, pop, push_data, top, empty, full, overflow, underflow).

Verification
REQ-035 Reset release, pc_sel=00, ready=1, memory mem[a]=a+0x100 -> pc_out 0,1,2,... one per cycle from cycle 2, instr_out 0x100,0x101,...
REQ-036 instr_ready low 3 cycles while instr_valid at pc_out=5 -> instr_out/pc_out held at 5, then 6,7 follow with no gap or loss.
REQ-037 pc_sel=10, br_target=0x40, call=1 at pc_q=0x12 -> next valid pc_out 0x40, the F2 entry squashed; later pc_sel=01 -> fetch resumes at 0x13.
REQ-038 RAS_DEPTH=4, five calls pushing 1..5 -> ras_overflow one pulse on fifth; four pops return 5,4,3,2; fifth pop -> ras_underflow, PC=RESET_PC.
REQ-039 flush with br_target=0x80 during a stall -> instr_valid 0 next cycle, next valid pc_out 0x80; pc_q=0xFF sequential -> next 0x00.

Source files
------------

// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction fetch stage.
// The pc_sel encodings tell the fetch stage where the next PC comes from:
//   PCSEL_SEQ  : fall through to pc + 1
//   PCSEL_RET  : return to the address on top of the return-address stack
//   PCSEL_BR   : jump to br_target
//   PCSEL_HOLD : keep fetching from the current PC
// ----------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        PCSEL_SEQ  = 2'b00,
        PCSEL_RET  = 2'b01,
        PCSEL_BR   = 2'b10,
        PCSEL_HOLD = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/if_stage_return_stack.sv
// ----------------------------------------------------------------------------
// return_stack
// Circular return-address stack. A push onto a full stack silently replaces
// the oldest entry and raises a one-cycle overflow pulse. A pop from an empty
// stack leaves it empty and raises a one-cycle underflow pulse. A push and a
// pop in the same cycle replace the top entry in place.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   push, pop           stack operations for this cycle
//   push_data [AW]      address written by a push
//   top [AW]            current top-of-stack entry
//   empty, full         occupancy status
//   overflow            registered pulse, push while full
//   underflow           registered pulse, pop while empty
// ----------------------------------------------------------------------------
module return_stack #(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec, wr_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_en;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(RAS_DEPTH));
    assign top       = mem_q[ptr_q];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // The pointer wraps explicitly so that depths which are not a power of
    // two still behave as a ring.
    assign ptr_inc = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - PW'(1);

    // When full, advancing the pointer lands on the oldest entry, so a push
    // naturally overwrites it while the count stays saturated.
    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = ptr_q;
        if (push && pop) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_inc;
            ptr_d  = ptr_inc;
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage needs no reset: the count decides which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Two-stage instruction fetch with a return-address stack.
//   F1 : pc_q is presented to the synchronous instruction memory
//   F2 : req_pc_q/req_v_q track the word returning from memory
//   out: instr_out/pc_out/instr_valid hold the fetched instruction until the
//        consumer takes it
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   pc_sel [2]                next-PC source (see if_pkg)
//   br_target [AW]            branch and flush target
//   call                      push pc_q + 1 onto the return stack
//   flush                     squash everything and restart at br_target
//   imem_addr [AW]            instruction memory address
//   imem_rdata [IW]           memory data for the previous cycle's address
//   instr_out [IW], pc_out [AW], instr_valid   fetched instruction
//   instr_ready               consumer accepts the output this cycle
//   ras_overflow, ras_underflow                one-cycle stack error pulses
// ----------------------------------------------------------------------------
module if_stage
    import if_pkg::*;
#(
    parameter int            AW        = 8,
    parameter int            IW        = 16,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pc_sel,
    input  logic [AW-1:0] br_target,
    input  logic          call,
    input  logic          flush,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] instr_out,
    output logic [AW-1:0] pc_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          ras_overflow,
    output logic          ras_underflow
);

    pc_sel_e       sel;
    logic          advance;
    logic [AW-1:0] pc_inc;
    logic          ras_push, ras_pop, ras_empty, ras_full;
    logic [AW-1:0] ras_top;

    logic [AW-1:0] pc_q, pc_d;
    logic          req_v_q, req_v_d;
    logic [AW-1:0] req_pc_q, req_pc_d;
    logic [IW-1:0] instr_out_q, instr_out_d;
    logic [AW-1:0] pc_out_q, pc_out_d;
    logic          instr_valid_q, instr_valid_d;

    assign sel     = pc_sel_e'(pc_sel);
    assign advance = !instr_valid_q || instr_ready;
    assign pc_inc  = pc_q + AW'(1);

    // While stalled, the F2 entry re-reads its own address so its data is
    // still on imem_rdata when the pipeline moves again.
    assign imem_addr = advance ? pc_q : req_pc_q;

    assign ras_push = advance && call && !flush;
    assign ras_pop  = advance && (sel == PCSEL_RET) && !flush;

    assign instr_out   = instr_out_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = instr_valid_q;

    return_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    // Redirects (return, branch) squash the word issued this cycle because it
    // is on the wrong path. Hold re-issues the same PC, so its F2 copy is
    // dropped to avoid delivering the instruction twice.
    always_comb begin
        pc_d          = pc_q;
        req_v_d       = req_v_q;
        req_pc_d      = req_pc_q;
        instr_out_d   = instr_out_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        if (flush) begin
            instr_valid_d = 1'b0;
            req_v_d       = 1'b0;
            pc_d          = br_target;
        end else if (advance) begin
            instr_out_d   = imem_rdata;
            pc_out_d      = req_pc_q;
            instr_valid_d = req_v_q;
            req_pc_d      = pc_q;
            case (sel)
                PCSEL_SEQ: begin
                    pc_d    = pc_inc;
                    req_v_d = 1'b1;
                end
                PCSEL_RET: begin
                    pc_d    = ras_empty ? RESET_PC : ras_top;
                    req_v_d = 1'b0;
                end
                PCSEL_BR: begin
                    pc_d    = br_target;
                    req_v_d = 1'b0;
                end
                PCSEL_HOLD: begin
                    pc_d    = pc_q;
                    req_v_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            req_v_q       <= 1'b0;
            req_pc_q      <= '0;
            instr_out_q   <= '0;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_v_q       <= req_v_d;
            req_pc_q      <= req_pc_d;
            instr_out_q   <= instr_out_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // The full flag is only needed inside the stack; keep it observable here.
    logic unused_full;
    assign unused_full = ras_full;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage with a synchronous memory model where
// mem[a] = a + 0x100. Inputs change on the falling edge and outputs are
// sampled on the falling edge, half a cycle away from the active edge.
// ----------------------------------------------------------------------------
module tb_if_stage;
    import if_pkg::*;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    pc_sel;
    logic [AW-1:0] br_target;
    logic          call;
    logic          flush;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] pc_out;
    logic          instr_valid;
    logic          instr_ready;
    logic          ras_overflow;
    logic          ras_underflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]    sel;
        logic          call;
        logic          flush;
        logic          ready;
        logic [AW-1:0] br;
        logic          exp_valid;
        logic [AW-1:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    if_stage #(
        .AW        (AW),
        .IW        (IW),
        .RAS_DEPTH (4),
        .RESET_PC  (8'h00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_sel        (pc_sel),
        .br_target     (br_target),
        .call          (call),
        .flush         (flush),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory with a recognisable data pattern.
    always @(posedge clk) imem_rdata <= memValue(imem_addr);

    function automatic logic [IW-1:0] memValue(input logic [AW-1:0] a);
        return IW'(a) + 16'h0100;
    endfunction

    function automatic vec_t mk(input logic [1:0] sel, input logic c, input logic f,
                                input logic r, input logic [AW-1:0] br,
                                input logic ev, input logic [AW-1:0] epc);
        vec_t v;
        v.sel = sel; v.call = c; v.flush = f; v.ready = r; v.br = br;
        v.exp_valid = ev; v.exp_pc = epc;
        return v;
    endfunction

    // Drive one cycle of inputs and return at the following falling edge.
    task automatic applyStimulus(input logic [1:0] sel, input logic c, input logic f,
                                 input logic r, input logic [AW-1:0] br);
        pc_sel = sel; call = c; flush = f; instr_ready = r; br_target = br;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkFetch(input string name, input logic ev, input logic [AW-1:0] epc);
        checkOutput({name, ".valid"}, 32'(instr_valid), 32'(ev));
        if (ev) begin
            checkOutput({name, ".pc"}, 32'(pc_out), 32'(epc));
            checkOutput({name, ".instr"}, 32'(instr_out), 32'(memValue(epc)));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int pop_exp[5];
        int budget;
        exp_t e;

        // ---------------- reset ----------------
        rst = 1'b0;
        pc_sel = PCSEL_SEQ; call = 1'b0; flush = 1'b0; instr_ready = 1'b1; br_target = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst.valid", 32'(instr_valid), 0);
        checkOutput("rst.pc_out", 32'(pc_out), 0);
        checkOutput("rst.instr_out", 32'(instr_out), 0);
        checkOutput("rst.flags", 32'({ras_overflow, ras_underflow}), 0);
        checkOutput("rst.imem_addr", 32'(imem_addr), 0);
        rst = 1'b1;

        // ---------------- table: streaming, stall, branch+call, return ----------------
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, N, 8'h00));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h00));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h01));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h02));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h03));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h04));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h05));
        vecs.push_back(mk(PCSEL_BR,   N, N, N, 8'h33, Y, 8'h05));
        vecs.push_back(mk(PCSEL_RET,  Y, N, N, 8'h33, Y, 8'h05));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, N, 8'h00, Y, 8'h05));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h06));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h07));
        vecs.push_back(mk(PCSEL_SEQ,  N, Y, Y, 8'h12, N, 8'h00));
        vecs.push_back(mk(PCSEL_BR,   Y, N, Y, 8'h40, N, 8'h00));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, N, 8'h00));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h40));
        vecs.push_back(mk(PCSEL_RET,  N, N, Y, 8'h00, Y, 8'h41));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, N, 8'h00));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h13));
        vecs.push_back(mk(PCSEL_SEQ,  N, N, Y, 8'h00, Y, 8'h14));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sel, vecs[i].call, vecs[i].flush, vecs[i].ready, vecs[i].br);
            checkFetch($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d.flags", i), 32'({ras_overflow, ras_underflow}), 0);
        end

        // ---------------- return stack: overflow then drain to underflow ----------------
        applyStimulus(PCSEL_SEQ, N, Y, Y, 8'h00);
        checkOutput("ras.flush_addr", 32'(imem_addr), 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(PCSEL_SEQ, Y, N, Y, 8'h00);
            checkOutput($sformatf("ras.push%0d.ovf", k), 32'(ras_overflow), (k == 5) ? 1 : 0);
            checkOutput($sformatf("ras.push%0d.addr", k), 32'(imem_addr), k);
        end
        pop_exp = '{5, 4, 3, 2, 0};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(PCSEL_RET, N, N, Y, 8'h00);
            checkOutput($sformatf("ras.pop%0d.addr", k), 32'(imem_addr), pop_exp[k]);
            checkOutput($sformatf("ras.pop%0d.unf", k), 32'(ras_underflow), (k == 4) ? 1 : 0);
            checkOutput($sformatf("ras.pop%0d.ovf", k), 32'(ras_overflow), 0);
        end
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkOutput("ras.unf_clear", 32'(ras_underflow), 0);
        checkOutput("ras.after_unf.addr", 32'(imem_addr), 1);

        // simultaneous pop and push replaces the top entry
        applyStimulus(PCSEL_SEQ, Y, N, Y, 8'h00);
        applyStimulus(PCSEL_RET, Y, N, Y, 8'h00);
        checkOutput("ras.poppush.addr", 32'(imem_addr), 2);
        checkOutput("ras.poppush.flags", 32'({ras_overflow, ras_underflow}), 0);
        applyStimulus(PCSEL_RET, N, N, Y, 8'h00);
        checkOutput("ras.poppush.next", 32'(imem_addr), 3);
        applyStimulus(PCSEL_RET, N, N, Y, 8'h00);
        checkOutput("ras.poppush.unf", 32'(ras_underflow), 1);
        checkOutput("ras.poppush.reset_pc", 32'(imem_addr), 0);

        // ---------------- flush during a stall ----------------
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkFetch("stall_pre", Y, 8'h00);
        applyStimulus(PCSEL_SEQ, N, Y, N, 8'h80);
        checkOutput("flush.valid", 32'(instr_valid), 0);
        checkOutput("flush.addr", 32'(imem_addr), 32'h80);
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkFetch("flush.gap", N, 8'h00);
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkFetch("flush.first", Y, 8'h80);

        // ---------------- PC wrap ----------------
        applyStimulus(PCSEL_SEQ, N, Y, Y, 8'hFF);
        checkOutput("wrap.addr_ff", 32'(imem_addr), 32'hFF);
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkOutput("wrap.addr_00", 32'(imem_addr), 0);
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkFetch("wrap.out_ff", Y, 8'hFF);
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkFetch("wrap.out_00", Y, 8'h00);
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkFetch("wrap.out_01", Y, 8'h01);

        // ---------------- asynchronous reset while stalled ----------------
        applyStimulus(PCSEL_SEQ, N, N, N, 8'h00);
        checkFetch("rst_stall.held", Y, 8'h01);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_async.valid", 32'(instr_valid), 0);
        checkOutput("rst_async.pc_out", 32'(pc_out), 0);
        checkOutput("rst_async.instr_out", 32'(instr_out), 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkFetch("rst_release.gap", N, 8'h00);
        applyStimulus(PCSEL_SEQ, N, N, Y, 8'h00);
        checkFetch("rst_release.first", Y, 8'h00);

        // ---------------- scoreboard: sequential stream under random back-pressure ----------------
        applyStimulus(PCSEL_SEQ, N, Y, Y, 8'h20);
        for (int i = 0; i < 24; i++) begin
            e.pc = AW'(8'h20 + i);
            e.instr = memValue(e.pc);
            sb.push_back(e);
        end
        budget = 300;
        while (sb.size() > 0 && budget > 0) begin
            if (instr_valid && instr_ready) begin
                e = sb.pop_front();
                checkOutput("sb.pc", 32'(pc_out), 32'(e.pc));
                checkOutput("sb.instr", 32'(instr_out), 32'(e.instr));
            end
            if (sb.size() > 0) begin
                applyStimulus(PCSEL_SEQ, N, N, 1'($urandom_range(0, 1)), 8'h00);
            end
            budget--;
        end
        checkOutput("sb.drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
